// File: rtl/banked_byte_store_pkg.sv
// Shared constants for the banked byte store: FSM encoding and board/bench defaults.
package banked_byte_store_pkg;

   typedef logic [0:0] state_t;

   localparam state_t ST_IDLE  = 1'b0;
   localparam state_t ST_CLEAR = 1'b1;

   localparam int DEF_WIDTH    = 8;
   localparam int DEF_DEPTH    = 4;
   localparam int DEF_SCAN_DIV = 50_000_000;
   localparam int SIM_SCAN_DIV = 4;

endpackage

// File: rtl/banked_byte_store_rise_detect.sv
// Single-cycle pulse on each rising edge of a level input; history clears on reset.
module rise_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic in_i,
   output logic pulse_o
);

   logic in_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_q <= 1'b0;
      end else begin
         in_q <= in_i;
      end
   end

   assign pulse_o = in_i & ~in_q;

endmodule

// File: rtl/banked_byte_store.sv
// DEPTH x WIDTH register-file memory with edge-qualified store, sequenced bulk clear
// and an auto-scan display; busy doubles as the visible FSM state.
module banked_byte_store
   import banked_byte_store_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int SCAN_DIV = DEF_SCAN_DIV,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] data,
   input  logic             store,
   input  logic             clear,
   input  logic             scan_en,
   input  logic [AW-1:0]    addr,
   output logic [WIDTH-1:0] memory,
   output logic [AW-1:0]    shown_addr,
   output logic             busy
);

   localparam int PW = $clog2(SCAN_DIV + 1);
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
   localparam logic [PW-1:0] PRESC_TC  = PW'(SCAN_DIV - 1);

   logic store_pulse;
   logic clear_pulse;

   rise_detect u_store_rise (
      .clk     (clk),
      .rst_n   (rst_n),
      .in_i    (store),
      .pulse_o (store_pulse)
   );

   rise_detect u_clear_rise (
      .clk     (clk),
      .rst_n   (rst_n),
      .in_i    (clear),
      .pulse_o (clear_pulse)
   );

   state_t          state_q, state_d;
   logic [AW-1:0]   clr_ptr_q, clr_ptr_d;
   logic            we;
   logic [AW-1:0]   waddr;
   logic [WIDTH-1:0] wdata;

   // While clearing, button pulses are consumed by the edge detectors and dropped.
   always_comb begin
      state_d   = state_q;
      clr_ptr_d = clr_ptr_q;
      we        = 1'b0;
      waddr     = addr;
      wdata     = data;
      if (state_q == ST_IDLE) begin
         if (clear_pulse) begin
            state_d   = ST_CLEAR;
            clr_ptr_d = '0;
         end else if (store_pulse) begin
            we = 1'b1;
         end
      end else begin
         we        = 1'b1;
         waddr     = clr_ptr_q;
         wdata     = '0;
         clr_ptr_d = clr_ptr_q + AW'(1);
         if (clr_ptr_q == LAST_ADDR) begin
            state_d = ST_IDLE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         clr_ptr_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_ptr_q <= clr_ptr_d;
      end
   end

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   logic [PW-1:0] presc_q, presc_d;
   logic [AW-1:0] scan_q, scan_d;

   // Holding both counters at zero while scan_en is low makes each scan start at address 0.
   always_comb begin
      presc_d = presc_q;
      scan_d  = scan_q;
      if (!scan_en) begin
         presc_d = '0;
         scan_d  = '0;
      end else if (presc_q == PRESC_TC) begin
         presc_d = '0;
         scan_d  = scan_q + AW'(1);
      end else begin
         presc_d = presc_q + PW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q <= '0;
         scan_q  <= '0;
      end else begin
         presc_q <= presc_d;
         scan_q  <= scan_d;
      end
   end

   logic [AW-1:0]    disp_addr;
   logic [WIDTH-1:0] memory_q;
   logic [AW-1:0]    shown_addr_q;

   assign disp_addr = scan_en ? scan_q : addr;

   // Reads the pre-write array, so a write to the displayed word shows one cycle later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         memory_q     <= '0;
         shown_addr_q <= '0;
      end else begin
         memory_q     <= mem_q[disp_addr];
         shown_addr_q <= disp_addr;
      end
   end

   assign memory     = memory_q;
   assign shown_addr = shown_addr_q;
   assign busy       = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_banked_byte_store.sv
// Directed bench for banked_byte_store with the short scan divider.
module tb_banked_byte_store;
   import banked_byte_store_pkg::*;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
   localparam int AW    = 2;

   logic             clk;
   logic             rst_n;
   logic [WIDTH-1:0] data;
   logic             store;
   logic             clear;
   logic             scan_en;
   logic [AW-1:0]    addr;
   logic [WIDTH-1:0] memory;
   logic [AW-1:0]    shown_addr;
   logic             busy;

   int n_checks = 0;
   int n_pass   = 0;

   banked_byte_store #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .SCAN_DIV (SIM_SCAN_DIV)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .data       (data),
      .store      (store),
      .clear      (clear),
      .scan_en    (scan_en),
      .addr       (addr),
      .memory     (memory),
      .shown_addr (shown_addr),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_word(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
      addr  = a;
      data  = d;
      store = 1'b1;
      tick();
      store = 1'b0;
      tick();
   endtask

   task automatic read_word(input logic [AW-1:0] a, output logic [WIDTH-1:0] v);
      scan_en = 1'b0;
      addr    = a;
      tick();
      v = memory;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (busy && n < 20) begin
         tick();
         n++;
      end
      n_checks++;
      if (busy !== 1'b0) $display("FAIL %s: busy still %b after %0d cycles, required 0", name, busy, n);
      else n_pass++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; data = '0; store = 1'b0; clear = 1'b0; scan_en = 1'b0; addr = 2'd2;
      repeat (3) tick();
      n_checks++;
      if (memory !== 8'h00 || busy !== 1'b0 || shown_addr !== 2'd0)
         $display("FAIL reset_hold: memory=%h shown=%0d busy=%b, required 00/0/0", memory, shown_addr, busy);
      else n_pass++;
      rst_n = 1'b1;
      tick();
      tick();
      n_checks++;
      if (memory !== 8'h00) $display("FAIL reset_memory: got %h, required 00", memory);
      else n_pass++;
      n_checks++;
      if (shown_addr !== 2'd2) $display("FAIL reset_shown_addr: got %0d, required 2", shown_addr);
      else n_pass++;
      n_checks++;
      if (busy !== 1'b0) $display("FAIL reset_busy: got %b, required 0", busy);
      else n_pass++;
   endtask

   task automatic test_single_write();
      logic [WIDTH-1:0] v;
      addr = 2'd1; data = 8'hA5; store = 1'b1;
      tick();
      n_checks++;
      if (memory !== 8'h00) $display("FAIL write_read_before_write: got %h, required 00", memory);
      else n_pass++;
      tick();
      n_checks++;
      if (memory !== 8'hA5) $display("FAIL write_one_cycle_later: got %h, required a5", memory);
      else n_pass++;
      data = 8'h3C;
      repeat (8) tick();
      n_checks++;
      if (memory !== 8'hA5) $display("FAIL write_held_store: got %h, required a5", memory);
      else n_pass++;
      store = 1'b0;
      tick();
      read_word(2'd1, v);
      n_checks++;
      if (v !== 8'hA5) $display("FAIL write_single_event: mem[1]=%h, required a5", v);
      else n_pass++;
   endtask

   task automatic test_clear();
      logic [WIDTH-1:0] v;
      int cnt;
      for (int i = 0; i < DEPTH; i++) write_word(AW'(i), 8'(8'h11 * (i + 1)));
      for (int i = 0; i < DEPTH; i++) begin
         read_word(AW'(i), v);
         n_checks++;
         if (v !== 8'(8'h11 * (i + 1))) $display("FAIL fill_word%0d: got %h, required %h", i, v, 8'(8'h11 * (i + 1)));
         else n_pass++;
      end
      clear = 1'b1;
      tick();
      clear = 1'b0;
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         if (busy) cnt++;
         if (i == 1) begin addr = 2'd0; data = 8'h77; store = 1'b1; end
         if (i == 2) store = 1'b0;
         tick();
      end
      n_checks++;
      if (cnt !== DEPTH) $display("FAIL clear_busy_cycles: got %0d, required %0d", cnt, DEPTH);
      else n_pass++;
      for (int i = 0; i < DEPTH; i++) begin
         read_word(AW'(i), v);
         n_checks++;
         if (v !== 8'h00) $display("FAIL clear_word%0d: got %h, required 00", i, v);
         else n_pass++;
      end
   endtask

   task automatic test_same_cycle();
      logic [WIDTH-1:0] v;
      write_word(2'd3, 8'h5A);
      addr = 2'd3; data = 8'hFF; store = 1'b1; clear = 1'b1;
      tick();
      store = 1'b0; clear = 1'b0;
      n_checks++;
      if (busy !== 1'b1) $display("FAIL same_cycle_busy: got %b, required 1", busy);
      else n_pass++;
      wait_idle("same_cycle_idle");
      read_word(2'd3, v);
      n_checks++;
      if (v !== 8'h00) $display("FAIL same_cycle_mem3: got %h, required 00", v);
      else n_pass++;
   endtask

   task automatic test_scan();
      logic [AW-1:0]    exp_a;
      logic [WIDTH-1:0] exp_d;
      for (int i = 0; i < DEPTH; i++) write_word(AW'(i), 8'(8'h11 * (i + 1)));
      addr = 2'd2;
      scan_en = 1'b1;
      for (int k = 0; k < 20; k++) begin
         tick();
         exp_a = AW'((k / 4) % 4);
         exp_d = 8'(8'h11 * (int'(exp_a) + 1));
         n_checks++;
         if (shown_addr !== exp_a) $display("FAIL scan_addr_k%0d: got %0d, required %0d", k, shown_addr, exp_a);
         else n_pass++;
         n_checks++;
         if (memory !== exp_d) $display("FAIL scan_data_k%0d: got %h, required %h", k, memory, exp_d);
         else n_pass++;
      end
      scan_en = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_clear();
      logic [WIDTH-1:0] v;
      for (int i = 0; i < DEPTH; i++) write_word(AW'(i), 8'hEE);
      addr = 2'd3;
      clear = 1'b1;
      tick();
      clear = 1'b0;
      tick();
      tick();
      n_checks++;
      if (memory !== 8'hEE || busy !== 1'b1) $display("FAIL mid_clear_pre: memory=%h busy=%b, required ee/1", memory, busy);
      else n_pass++;
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (memory !== 8'h00 || shown_addr !== 2'd0 || busy !== 1'b0)
         $display("FAIL mid_clear_async: memory=%h shown=%0d busy=%b, required 00/0/0", memory, shown_addr, busy);
      else n_pass++;
      #1 rst_n = 1'b1;
      repeat (3) tick();
      n_checks++;
      if (busy !== 1'b0) $display("FAIL mid_clear_no_resume: busy=%b, required 0", busy);
      else n_pass++;
      for (int i = 0; i < DEPTH; i++) begin
         read_word(AW'(i), v);
         n_checks++;
         if (v !== 8'h00) $display("FAIL mid_clear_word%0d: got %h, required 00", i, v);
         else n_pass++;
      end
      write_word(2'd2, 8'h99);
      read_word(2'd2, v);
      n_checks++;
      if (v !== 8'h99) $display("FAIL post_reset_store: got %h, required 99", v);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_clear();
      test_same_cycle();
      test_scan();
      test_reset_mid_clear();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/banked_byte_store.md
Name: banked_byte_store

Overview:
- Parametrised successor to the 4-entry byte memory on the switch/LED lab board: a DEPTH x WIDTH clocked register-file memory with edge-qualified writes, a sequenced bulk-clear and an auto-scan display mode.
- Sits between the board switches/buttons and the LED bank.
- Debounced buttons drive store and clear.
- The memory output drives the LEDs; shown_addr drives the address indicator LEDs.

Parameters:
- WIDTH, 8, bits per word.
- DEPTH, 4, number of words; power of two, minimum 2.
- SCAN_DIV, 50_000_000, clock cycles per address step in scan mode; minimum 1.
- AW (localparam), $clog2(DEPTH), address width.

Ports:
- Interface (already decided): one clock; reset is asynchronous and active-low.
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- data  input  WIDTH  write data.
- store  input  1  write request (level); its rising edge writes data to addr.
- clear  input  1  bulk-clear request (level); its rising edge starts a clear.
- scan_en  input  1  1 = auto-scan display; 0 = display addr.
- addr  input  AW  write address, and display address when scan_en=0.
- memory  output  WIDTH  registered contents of the displayed word.
- shown_addr  output  AW  address currently displayed.
- busy  output  1  high while a clear sequence runs.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All DEPTH words = 0.
  - memory=0, shown_addr=0, busy=0.
  - State=IDLE; scan counter and prescaler = 0.
  - Edge-detect history registers = 0, so an input held high through reset release does not fire.
- Edge detection: one registered history bit per input.
  - store_pulse = store & ~store_q; clear_pulse likewise.
  - Exactly one event per rising edge, regardless of how long the input is held.
- FSM states IDLE, CLEAR.
  - IDLE, clear_pulse: go to CLEAR; clr_ptr=0; busy=1 from the next cycle.
  - IDLE, store_pulse with no clear_pulse: mem[addr] <= data on that clock edge.
  - Same cycle store_pulse and clear_pulse: clear wins; the store is dropped.
  - CLEAR: mem[clr_ptr] <= 0 each cycle, clr_ptr increments.
  - CLEAR at clr_ptr==DEPTH-1: write that word, then return to IDLE; busy=0 the following cycle.
  - busy is high for exactly DEPTH cycles.
  - CLEAR: store_pulse and clear_pulse are ignored and discarded, not queued.
- Display address:
  - scan_en=0: disp_addr = addr.
  - scan_en=1: disp_addr = scan counter. The prescaler counts 0..SCAN_DIV-1; on terminal count the scan counter increments, wrapping DEPTH-1 -> 0.
  - Rising edge of scan_en: scan counter and prescaler reset to 0.
  - scan_en=0: scan counter and prescaler hold at 0.
- Output:
  - memory <= mem[disp_addr] and shown_addr <= disp_addr every cycle; 1-cycle latency.
  - Write to the displayed address: read-before-write. memory shows the old value on the write edge and the new value one cycle later.
  - The display keeps updating during CLEAR, showing zeros as they land.
- Reset asserted mid-CLEAR: immediate return to IDLE with all words 0; no resumption.
- Widths: all counters sized exactly; the wrap relies on AW-bit overflow. SCAN_DIV counter width = $clog2(SCAN_DIV+1).

Decomposition:
- Shared package/header holds:
  - FSM state encoding (IDLE=1'b0, CLEAR=1'b1).
  - Default WIDTH/DEPTH/SCAN_DIV constants for the board top.
  - SIM_SCAN_DIV=4 for benches.
- Sub-module: rise_detect (async active-low reset, one flop plus AND). Instantiated twice, for store and clear.
- Storage, FSM and scan logic stay in banked_byte_store.

Test Plan:
- Reset, scan_en=0, addr=2: after 2 clocks memory=0x00, shown_addr=2, busy=0.
- Write 0xA5 to addr 1 with store held 10 cycles, then data=0x3C still held: mem[1]=0xA5 only (single write). memory reads 0xA5 one cycle after the write edge.
- Fill words 0..3 with 0x11,0x22,0x33,0x44; pulse clear:
  - busy high exactly 4 cycles.
  - A store pulse at addr 0 during busy is dropped.
  - Afterwards all words read 0x00.
- store and clear rising on the same cycle with data=0xFF, addr=3: mem[3]=0x00 and the CLEAR sequence runs.
- SCAN_DIV=4, words 0x11..0x44, scan_en 0->1: shown_addr steps 0,1,2,3,0 every 4 cycles; memory follows one cycle behind the address register.
- rst_n pulsed low mid-CLEAR (clr_ptr=2), previously all 0xEE: outputs zero immediately, busy=0, all words 0, store works on the next rising edge.
